tnn_serial_neuron: RTL and testbench



---
 rtl/tnn_serial_neuron.sv | 123 ++++++++++++
 tb/tb_tnn_serial_neuron.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_serial_neuron.sv
// tnn_serial_neuron: sequential threshold neuron for the TNN datapath.
// Accepts N_IN unsigned W-bit operands in one valid/ready handshake, then
// accumulates them one per cycle into a signed AW-bit sum. Operands whose
// POS_MASK bit is set are added and the others are subtracted. The result is
// presented as a firing bit (sum > THRESH, signed) plus the signed margin.
//
// Optional feature macro: APPROX_TRUNC_EN
//   defined   : the TRUNC_BITS LSBs of every operand are zeroed before accumulation
//   undefined : exact accumulation, TRUNC_BITS has no effect
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for an operand vector, in_ready = 1
// ACCUM  | adding/subtracting operand[idx], one per cycle
// DONE   | result held on out_* with out_valid = 1 until out_ready

module tnn_serial_neuron #(
    parameter int              N_IN       = 5,
    parameter int              W          = 3,
    parameter logic [N_IN-1:0] POS_MASK   = 5'b10110,
    parameter int              THRESH     = 0,
    parameter int              TRUNC_BITS = 1,
    localparam int             AW         = W + $clog2(N_IN) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_bit,
    output logic signed [AW-1:0]   out_margin
);

    localparam int IW = $clog2(N_IN);

`ifdef APPROX_TRUNC_EN
    localparam int DROP = TRUNC_BITS;
`else
    // exact accumulation keeps every operand bit; TRUNC_BITS is accepted but inert
    localparam int DROP = 0 * TRUNC_BITS;
`endif

    localparam logic [W-1:0]         OP_MASK  = ~W'((1 << DROP) - 1);
    localparam logic signed [AW-1:0] THRESH_S = AW'(THRESH);
    localparam logic [IW-1:0]        LAST_IDX = IW'(N_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [N_IN*W-1:0]     data_q;
    logic signed [AW-1:0]  acc;
    logic [IW-1:0]         idx;

    logic [W-1:0]          op_raw;
    logic [W-1:0]          op_eff;
    logic signed [AW-1:0]  op_ext;
    logic signed [AW-1:0]  acc_next;

    // select the current operand, apply optional truncation and the polarity
    always_comb begin
        op_raw   = data_q[idx*W +: W];
        op_eff   = op_raw & OP_MASK;
        op_ext   = {{(AW-W){1'b0}}, op_eff};
        acc_next = POS_MASK[idx] ? (acc + op_ext) : (acc - op_ext);
    end

    // sequencing FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            data_q     <= '0;
            acc        <= '0;
            idx        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
            out_margin <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q   <= in_data;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= acc_next;
                    if (idx == LAST_IDX) begin
                        // result registers are loaded from the final sum directly
                        out_margin <= acc_next;
                        out_bit    <= (acc_next > THRESH_S);
                        out_valid  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tnn_serial_neuron.sv
// Self-checking bench for tnn_serial_neuron with default parameters.
// Reference model computes the signed margin directly from the operand list.
// Honours APPROX_TRUNC_EN so the same bench covers both builds.

module tb_tnn_serial_neuron;

    localparam int              N_IN       = 5;
    localparam int              W          = 3;
    localparam logic [N_IN-1:0] POS_MASK   = 5'b10110;
    localparam int              THRESH     = 0;
    localparam int              TRUNC_BITS = 1;
    localparam int              AW         = W + $clog2(N_IN) + 1;
    localparam int              DW         = N_IN * W;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_bit;
    logic signed [AW-1:0]  out_margin;

    int checks = 0;
    int errors = 0;

    tnn_serial_neuron #(
        .N_IN      (N_IN),
        .W         (W),
        .POS_MASK  (POS_MASK),
        .THRESH    (THRESH),
        .TRUNC_BITS(TRUNC_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_margin(out_margin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pack(input int a, input int b, input int c,
                                           input int d, input int e);
        logic [W-1:0] o [N_IN];
        logic [DW-1:0] v;
        o[0] = W'(a); o[1] = W'(b); o[2] = W'(c); o[3] = W'(d); o[4] = W'(e);
        v = '0;
        for (int i = 0; i < N_IN; i++) v[i*W +: W] = o[i];
        return v;
    endfunction

    function automatic int model_margin(input logic [DW-1:0] d);
        int s;
        int op;
        logic [W-1:0] o;
        s = 0;
        for (int i = 0; i < N_IN; i++) begin
            o  = d[i*W +: W];
            op = int'(o);
`ifdef APPROX_TRUNC_EN
            op = op - (op % (1 << TRUNC_BITS));
`endif
            if (POS_MASK[i]) s = s + op;
            else             s = s - op;
        end
        return s;
    endfunction

    // one full transaction: accept, latency, result, optional back-pressure, release
    task automatic run_vector(input string name, input logic [DW-1:0] data,
                              input int exp_m, input logic exp_b, input int hold);
        logic signed [AW-1:0] em;
        em = AW'(exp_m);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept: in_ready=%b required 1", name, in_ready);
        end
        in_valid = 1'b1;
        in_data  = data;
        tick();
        for (int k = 1; k <= N_IN; k++) begin
            in_valid = 1'($urandom);
            in_data  = DW'($urandom);
            if (k > 1) tick();
            if (k < N_IN) begin
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_cycle%0d: out_valid=%b in_ready=%b required 0 0",
                             name, k, out_valid, in_ready);
                end
            end
        end
        if (N_IN > 1) tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: out_valid=%b required 1 at accept+%0d", name, out_valid, N_IN);
        end
        checks++;
        if (out_margin !== em || out_bit !== exp_b) begin
            errors++;
            $display("FAIL %s result: margin=%0d bit=%b required margin=%0d bit=%b",
                     name, out_margin, out_bit, exp_m, exp_b);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            in_data  = DW'($urandom);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_margin !== em || out_bit !== exp_b || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b margin=%0d bit=%b ready=%b required 1 %0d %b 0",
                         name, h, out_valid, out_margin, out_bit, in_ready, exp_m, exp_b);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_after: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_bit !== 1'b0 || out_margin !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b bit=%b margin=%0d ready=%b required 0 0 0 1",
                     out_valid, out_bit, out_margin, in_ready);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
`ifdef APPROX_TRUNC_EN
        run_vector("mixed",   pack(0, 3, 2, 4, 1),  0, 1'b0, 0);
        run_vector("equal",   pack(2, 1, 1, 2, 2), -2, 1'b0, 0);
        run_vector("neg_ext", pack(7, 0, 0, 7, 0), -12, 1'b0, 0);
        run_vector("pos_ext", pack(0, 7, 7, 0, 7), 18, 1'b1, 0);
        run_vector("trunc",   pack(0, 1, 1, 0, 1),  0, 1'b0, 0);
`else
        run_vector("mixed",   pack(0, 3, 2, 4, 1),  2, 1'b1, 0);
        run_vector("equal",   pack(2, 1, 1, 2, 2),  0, 1'b0, 0);
        run_vector("neg_ext", pack(7, 0, 0, 7, 0), -14, 1'b0, 0);
        run_vector("pos_ext", pack(0, 7, 7, 0, 7), 21, 1'b1, 0);
        run_vector("trunc",   pack(0, 1, 1, 0, 1),  3, 1'b1, 0);
`endif
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d;
        int m;
        d = pack(0, 6, 5, 1, 3);
        m = model_margin(d);
        run_vector("backpressure", d, m, 1'(m > THRESH), 3);
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        int m;
        for (int n = 0; n < 20; n++) begin
            d = DW'($urandom);
            m = model_margin(d);
            run_vector("random", d, m, 1'(m > THRESH), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid_accum();
        bit seen;
        // leave a nonzero result in the output registers first
        run_vector("pre_reset", pack(0, 7, 7, 0, 7), model_margin(pack(0, 7, 7, 0, 7)), 1'b1, 0);
        in_valid = 1'b1;
        in_data  = pack(0, 7, 7, 0, 7);
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_bit !== 1'b0 || out_margin !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_accum: valid=%b bit=%b margin=%0d ready=%b required 0 0 0 1",
                     out_valid, out_bit, out_margin, in_ready);
        end
        seen = 1'b0;
        for (int k = 0; k < 2 * N_IN; k++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_result: out_valid seen=1 required 0");
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        int m;
        int lat;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            d = DW'($urandom);
            m = model_margin(d);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: in_ready=%b required 1", n, in_ready);
            end
            in_valid = 1'b1;
            in_data  = d;
            tick();
            in_valid = 1'b0;
            lat = 0;
            while (out_valid !== 1'b1 && lat < N_IN + 4) begin
                tick();
                lat++;
            end
            checks++;
            if (lat != N_IN) begin
                errors++;
                $display("FAIL b2b_latency%0d: cycles=%0d required %0d", n, lat, N_IN);
            end
            checks++;
            if (out_margin !== AW'(m) || out_bit !== 1'(m > THRESH)) begin
                errors++;
                $display("FAIL b2b_result%0d: margin=%0d bit=%b required margin=%0d bit=%b",
                         n, out_margin, out_bit, m, m > THRESH);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_done_len%0d: out_valid=%b in_ready=%b required 0 1",
                         n, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_accum();
        test_directed();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
